// File: rtl/cfg_chain_pkg.sv
// Shared types and frame-geometry helpers for the configuration daisy-chain node.
// Frame geometry changes when CFG_CHAIN_CHECK_EN is defined (one XOR trailer beat per frame).
package cfg_chain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_APPLY  = 3'd2,
    ST_BYPASS = 3'd3,
    ST_BCAST  = 3'd4
  } cfg_state_e;

  // Broadcast header: all ones across the ID field.
  function automatic logic [31:0] bcast_id(input int unsigned id_width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(id_width)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int unsigned id_beats(input int unsigned id_width,
                                           input int unsigned chain_w);
    return id_width / chain_w;
  endfunction

  function automatic int unsigned pay_beats(input int unsigned cfg_size,
                                            input int unsigned chain_w);
    return cfg_size / chain_w;
  endfunction

  // Wide enough to index every header, payload and trailer beat without wrapping.
  function automatic int unsigned cnt_width(input int unsigned id_width,
                                            input int unsigned cfg_size,
                                            input int unsigned chain_w);
    return $clog2(id_beats(id_width, chain_w) + pay_beats(cfg_size, chain_w) + 1);
  endfunction

endpackage

// File: rtl/cfg_shadow_shift.sv
// Shift-in shadow register feeding the committed configuration word.
// The shadow fills LSB-first; `cfg` is replaced in one edge on commit.
module cfg_shadow_shift
  import cfg_chain_pkg::*;
#(
  parameter int                    CFG_SIZE = 256,
  parameter int                    CHAIN_W  = 1,
  parameter logic [CFG_SIZE-1:0]   CFG_INIT = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                shift_en,
  input  logic [CHAIN_W-1:0]  shift_data,
  input  logic                commit,
  output logic [CFG_SIZE-1:0] cfg
);

  logic [CFG_SIZE-1:0] shadow_q;
  logic [CFG_SIZE-1:0] shadow_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    shadow_d = shadow_q;
    if (clear) begin
      shadow_d = '0;
    end else if (shift_en) begin
      // New beat enters at the top; after all beats the first one sits at bit 0.
      shadow_d = CFG_SIZE'({shift_data, shadow_q} >> CHAIN_W);
    end
  end

  // NOTE: the shadow is real state that gates what gets committed, so it is reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cfg      <= CFG_INIT;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      shadow_q <= shadow_d;
      if (commit) cfg <= shadow_d;
    end
  end

endmodule

// File: rtl/cfg_chain_node.sv
// Configuration daisy-chain endpoint: decodes an ID header, applies matching or broadcast
// payloads atomically to `cfg`, and forwards non-matching frames. Optional macro: CFG_CHAIN_CHECK_EN.
module cfg_chain_node
  import cfg_chain_pkg::*;
#(
  parameter int                    CFG_SIZE = 256,
  parameter int                    CHAIN_W  = 1,
  parameter int                    ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0]   ID       = '0,
  parameter logic [CFG_SIZE-1:0]   CFG_INIT = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_in_valid,
  input  logic                cfg_in_start,
  input  logic [CHAIN_W-1:0]  cfg_in_data,
  output logic                cfg_out_valid,
  output logic                cfg_out_start,
  output logic [CHAIN_W-1:0]  cfg_out_data,
  output logic [CFG_SIZE-1:0] cfg,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int unsigned ID_BEATS  = id_beats(ID_WIDTH, CHAIN_W);
  localparam int unsigned PAY_BEATS = pay_beats(CFG_SIZE, CHAIN_W);
  localparam int unsigned CNT_W     = cnt_width(ID_WIDTH, CFG_SIZE, CHAIN_W);

  localparam logic [ID_WIDTH-1:0] BCAST    = ID_WIDTH'(bcast_id(ID_WIDTH));
  localparam logic [CNT_W-1:0]    LAST_HDR = CNT_W'(ID_BEATS - 1);
  localparam logic [CNT_W-1:0]    LAST_PAY = CNT_W'(ID_BEATS + PAY_BEATS - 1);
`ifdef CFG_CHAIN_CHECK_EN
  localparam logic [CNT_W-1:0]    TRAILER  = CNT_W'(ID_BEATS + PAY_BEATS);
  localparam logic [CNT_W-1:0]    LAST_BEAT = TRAILER;
`else
  localparam logic [CNT_W-1:0]    LAST_BEAT = LAST_PAY;
`endif

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_HDR    = 3'(ST_HDR);
  localparam logic [2:0] S_APPLY  = 3'(ST_APPLY);
  localparam logic [2:0] S_BYPASS = 3'(ST_BYPASS);
  localparam logic [2:0] S_BCAST  = 3'(ST_BCAST);

  if (CFG_SIZE % CHAIN_W != 0) begin : g_bad_cfg_size
    $error("cfg_chain_node: CFG_SIZE must be a multiple of CHAIN_W");
  end
  if (ID_WIDTH % CHAIN_W != 0) begin : g_bad_id_width
    $error("cfg_chain_node: ID_WIDTH must be a multiple of CHAIN_W");
  end
  if (ID == BCAST) begin : g_bad_id
    $error("cfg_chain_node: ID must not be the broadcast ID");
  end

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] id_q, id_d, id_shift;
  logic                sh_clear, sh_shift, sh_commit;
  logic                done_d, err_d, fwd;
`ifdef CFG_CHAIN_CHECK_EN
  logic [CHAIN_W-1:0]  xor_q, xor_d;
`endif

  function automatic logic [2:0] decide(input logic [ID_WIDTH-1:0] hdr);
    if (hdr == ID)    return S_APPLY;
    if (hdr == BCAST) return S_BCAST;
    return S_BYPASS;
  endfunction

  // Header accumulates LSB-first, exactly like the payload shadow.
  assign id_shift = ID_WIDTH'({cfg_in_data, id_q} >> CHAIN_W);

  // A start beat is always a header beat and goes downstream; after that only
  // frames still being decoded or not owned solely by this node are forwarded.
  assign fwd = cfg_in_valid &&
               (cfg_in_start || state_q == S_HDR || state_q == S_BYPASS || state_q == S_BCAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    sh_clear  = 1'b0;
    sh_shift  = 1'b0;
    sh_commit = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef CFG_CHAIN_CHECK_EN
    xor_d     = xor_q;
`endif
    if (cfg_in_valid) begin
      if (cfg_in_start) begin
        // A start anywhere but IDLE abandons the frame in flight; its shadow is dropped.
        err_d    = (state_q != S_IDLE);
        sh_clear = 1'b1;
        cnt_d    = CNT_W'(1);
        id_d     = id_shift;
`ifdef CFG_CHAIN_CHECK_EN
        xor_d    = '0;
`endif
        state_d  = (ID_BEATS == 1) ? decide(id_shift) : S_HDR;
      end else begin
        case (state_q)
          S_HDR: begin
            id_d  = id_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_HDR) state_d = decide(id_shift);
          end
          S_APPLY, S_BCAST: begin
`ifdef CFG_CHAIN_CHECK_EN
            if (cnt_q == TRAILER) begin
              if (cfg_in_data == xor_q) begin
                sh_commit = 1'b1;
                done_d    = 1'b1;
              end else begin
                err_d     = 1'b1;
              end
              state_d = S_IDLE;
            end else begin
              sh_shift = 1'b1;
              xor_d    = xor_q ^ cfg_in_data;
              cnt_d    = cnt_q + CNT_W'(1);
            end
`else
            sh_shift = 1'b1;
            if (cnt_q == LAST_PAY) begin
              sh_commit = 1'b1;
              done_d    = 1'b1;
              state_d   = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`endif
          end
          S_BYPASS: begin
            if (cnt_q == LAST_BEAT) state_d = S_IDLE;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      id_q          <= '0;
      cfg_out_valid <= 1'b0;
      cfg_out_start <= 1'b0;
      cfg_out_data  <= '0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      cfg_out_valid <= fwd;
      cfg_out_start <= fwd && cfg_in_start;
      cfg_out_data  <= fwd ? cfg_in_data : '0;
      cfg_done      <= done_d;
      cfg_err       <= err_d;
    end
  end

`ifdef CFG_CHAIN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xor_q <= '0;
    else        xor_q <= xor_d;
  end
`endif

  cfg_shadow_shift #(
    .CFG_SIZE (CFG_SIZE),
    .CHAIN_W  (CHAIN_W),
    .CFG_INIT (CFG_INIT)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (sh_clear),
    .shift_en   (sh_shift),
    .shift_data (cfg_in_data),
    .commit     (sh_commit),
    .cfg        (cfg)
  );

endmodule

// File: tb/tb_cfg_chain_node.sv
// Bench for cfg_chain_node: node ID 5 feeding a downstream node ID 3.
// Forwarded beats of the first node are scoreboarded; frames come from a vector table.
module tb_cfg_chain_node;

  localparam logic [15:0] INIT = 16'hC0DE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_start = 1'b0;
  logic [3:0]  in_data = '0;
  logic        a_out_valid, a_out_start, a_done, a_err;
  logic [3:0]  a_out_data;
  logic [15:0] a_cfg;
  logic        b_out_valid, b_out_start, b_done, b_err;
  logic [3:0]  b_out_data;
  logic [15:0] b_cfg;

  always #5 clk = ~clk;

  cfg_chain_node #(.CFG_SIZE(16), .CHAIN_W(4), .ID_WIDTH(4), .ID(4'd5), .CFG_INIT(INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_in_valid(in_valid), .cfg_in_start(in_start), .cfg_in_data(in_data),
    .cfg_out_valid(a_out_valid), .cfg_out_start(a_out_start), .cfg_out_data(a_out_data),
    .cfg(a_cfg), .cfg_done(a_done), .cfg_err(a_err)
  );

  cfg_chain_node #(.CFG_SIZE(16), .CHAIN_W(4), .ID_WIDTH(4), .ID(4'd3), .CFG_INIT(INIT)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_in_valid(a_out_valid), .cfg_in_start(a_out_start), .cfg_in_data(a_out_data),
    .cfg_out_valid(b_out_valid), .cfg_out_start(b_out_start), .cfg_out_data(b_out_data),
    .cfg(b_cfg), .cfg_done(b_done), .cfg_err(b_err)
  );

  typedef struct {
    logic       start;
    logic [3:0] data;
    int         stamp;
  } fwd_t;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] pay;
    int          gap;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_done;
  } vec_t;

  fwd_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each expected forwarded beat must appear on the output exactly one cycle after it was driven.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].stamp == cyc) begin
        fwd_t e;
        e = sb.pop_front();
        check("fwd_valid", a_out_valid, 1);
        check("fwd_start", a_out_start, e.start);
        check("fwd_data", a_out_data, e.data);
      end else begin
        check("fwd_quiet", a_out_valid, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic s, input logic [3:0] d, input logic fwd);
    in_valid = 1'b1;
    in_start = s;
    in_data  = d;
    if (fwd) sb.push_back(fwd_t'{start: s, data: d, stamp: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_frame(input logic [3:0] id, input logic [15:0] pay, input int gap);
    logic fwd_pay;
    fwd_pay = (id != 4'h5);
    beat(1'b1, id, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle(gap);
      beat(1'b0, pay[k*4 +: 4], fwd_pay);
    end
`ifdef CFG_CHAIN_CHECK_EN
    idle(gap);
    beat(1'b0, pay[3:0] ^ pay[7:4] ^ pay[11:8] ^ pay[15:12], fwd_pay);
`endif
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{4'h5, 16'h4321, 0, 16'h4321, INIT,     1'b1};
    tbl[1] = '{4'h3, 16'h5678, 0, 16'h4321, 16'h5678, 1'b0};
    tbl[2] = '{4'hF, 16'hDCBA, 2, 16'hDCBA, 16'hDCBA, 1'b1};
    tbl[3] = '{4'h7, 16'hF0F0, 1, 16'hDCBA, 16'hDCBA, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg", a_cfg, INIT);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    rst_n = 1'b1;
    idle(1);

    // Node 5 owns frame 0; node 3 only sees the truncated header and must ignore it.
    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].id, tbl[i].pay, tbl[i].gap);
      check($sformatf("v%0d_cfg", i), a_cfg, tbl[i].exp_a);
      check($sformatf("v%0d_done", i), a_done, tbl[i].exp_done);
      check($sformatf("v%0d_err", i), a_err, 0);
      idle(1);
      check($sformatf("v%0d_done_pulse", i), a_done, 0);
      idle(1);
      check($sformatf("v%0d_cfg_b", i), b_cfg, tbl[i].exp_b);
    end

    // Abort after two payload beats, then a clean frame.
    beat(1'b1, 4'h5, 1'b1);
    beat(1'b0, 4'h1, 1'b0);
    beat(1'b0, 4'h2, 1'b0);
    beat(1'b1, 4'h5, 1'b1);
    check("abort_err", a_err, 1);
    check("abort_cfg_hold", a_cfg, 16'hDCBA);
    for (int k = 0; k < 4; k++) beat(1'b0, 4'h9, 1'b0);
`ifdef CFG_CHAIN_CHECK_EN
    beat(1'b0, 4'h0, 1'b0);
`endif
    check("abort_next_cfg", a_cfg, 16'h9999);
    check("abort_next_done", a_done, 1);
    check("abort_next_err", a_err, 0);
    idle(2);

    // Reset in the middle of the payload.
    beat(1'b1, 4'h5, 1'b1);
    beat(1'b0, 4'h1, 1'b0);
    beat(1'b0, 4'h2, 1'b0);
    beat(1'b0, 4'h3, 1'b0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_cfg", a_cfg, INIT);
    check("midrst_cfg_b", b_cfg, INIT);
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_out_start", a_out_start, 0);
    check("midrst_out_data", a_out_data, 0);
    check("midrst_done", a_done, 0);
    check("midrst_err", a_err, 0);
    #2;
    rst_n = 1'b1;
    idle(1);
    send_frame(4'h5, 16'h9876, 0);
    check("postrst_cfg", a_cfg, 16'h9876);
    check("postrst_done", a_done, 1);
    check("postrst_err", a_err, 0);
    idle(1);

    // A beat without start while idle is neither applied nor forwarded.
    beat(1'b0, 4'h5, 1'b0);
    idle(2);
    check("stray_cfg", a_cfg, 16'h9876);
    check("stray_err", a_err, 0);

`ifdef CFG_CHAIN_CHECK_EN
    beat(1'b1, 4'h5, 1'b1);
    beat(1'b0, 4'h1, 1'b0);
    beat(1'b0, 4'h2, 1'b0);
    beat(1'b0, 4'h3, 1'b0);
    beat(1'b0, 4'h4, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    check("badtrl_err", a_err, 1);
    check("badtrl_done", a_done, 0);
    check("badtrl_cfg", a_cfg, 16'h9876);
    idle(1);
    check("badtrl_err_pulse", a_err, 0);
`endif

    idle(3);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
